// File: rtl/id_ex_skid_pkg.sv
// Shared RV32I core definitions: NOP encoding, op code numbering, decode bundle
// layout and the decode/execute boundary occupancy states.
package id_ex_skid_pkg;

  localparam int          XLEN    = 32;
  localparam int          OH_W    = 7;
  localparam logic [31:0] NOP_INS = 32'h00000013;  // ADDI x0,x0,0

  localparam logic [OH_W-1:0] OH_NONE  = 7'd0;
  localparam logic [OH_W-1:0] OH_LUI   = 7'd1;
  localparam logic [OH_W-1:0] OH_AUIPC = 7'd2;
  localparam logic [OH_W-1:0] OH_JAL   = 7'd3;
  localparam logic [OH_W-1:0] OH_JALR  = 7'd4;
  localparam logic [OH_W-1:0] OH_BEQ   = 7'd5;
  localparam logic [OH_W-1:0] OH_BNE   = 7'd6;
  localparam logic [OH_W-1:0] OH_BLT   = 7'd7;
  localparam logic [OH_W-1:0] OH_BGE   = 7'd8;
  localparam logic [OH_W-1:0] OH_BLTU  = 7'd9;
  localparam logic [OH_W-1:0] OH_BGEU  = 7'd10;
  localparam logic [OH_W-1:0] OH_LB    = 7'd11;
  localparam logic [OH_W-1:0] OH_LH    = 7'd12;
  localparam logic [OH_W-1:0] OH_LW    = 7'd13;
  localparam logic [OH_W-1:0] OH_LBU   = 7'd14;
  localparam logic [OH_W-1:0] OH_LHU   = 7'd15;
  localparam logic [OH_W-1:0] OH_ADDI  = 7'd19;
  localparam logic [OH_W-1:0] OH_SLTI  = 7'd20;
  localparam logic [OH_W-1:0] OH_SLTIU = 7'd21;
  localparam logic [OH_W-1:0] OH_XORI  = 7'd22;
  localparam logic [OH_W-1:0] OH_ORI   = 7'd23;
  localparam logic [OH_W-1:0] OH_ANDI  = 7'd24;
  localparam logic [OH_W-1:0] OH_SLLI  = 7'd25;
  localparam logic [OH_W-1:0] OH_SRLI  = 7'd26;
  localparam logic [OH_W-1:0] OH_SRAI  = 7'd27;
  localparam logic [OH_W-1:0] OH_ADD   = 7'd28;
  localparam logic [OH_W-1:0] OH_SUB   = 7'd29;
  localparam logic [OH_W-1:0] OH_SLL   = 7'd30;
  localparam logic [OH_W-1:0] OH_SLT   = 7'd31;
  localparam logic [OH_W-1:0] OH_SLTU  = 7'd32;
  localparam logic [OH_W-1:0] OH_XOR   = 7'd33;
  localparam logic [OH_W-1:0] OH_SRL   = 7'd34;
  localparam logic [OH_W-1:0] OH_SRA   = 7'd35;
  localparam logic [OH_W-1:0] OH_OR    = 7'd36;
  localparam logic [OH_W-1:0] OH_AND   = 7'd37;

  // Encoded as {skid_valid, out_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } skid_state_e;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [31:0]     ins;
    logic [XLEN-1:0] ins_addr;
    logic [4:0]      rd_addr;
    logic            rd_wen;
    logic [OH_W-1:0] oh;
  } bundle_t;

endpackage

// File: rtl/id_ex_slot.sv
// One bundle register with a valid flag; clear returns it to the NOP payload
// and wins over load.
module id_ex_slot #(
  parameter int         W       = 8,
  parameter logic [W-1:0] NOP_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_reg;
  logic [W-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      q_reg     <= NOP_VAL;
    end else if (clear) begin
      valid_reg <= 1'b0;
      q_reg     <= NOP_VAL;
    end else if (load) begin
      valid_reg <= 1'b1;
      q_reg     <= d;
    end
  end

  assign valid = valid_reg;
  assign q     = q_reg;

endmodule

// File: rtl/id_ex_skid.sv
// Decode-to-execute boundary register with a 2-entry skid buffer and flush.
// Define ID_EX_SKID_PERF_EN to add the stall_cnt/flush_cnt counters.
module id_ex_skid #(
  parameter int          XLEN    = id_ex_skid_pkg::XLEN,
  parameter int          OH_W    = id_ex_skid_pkg::OH_W,
  parameter logic [31:0] NOP_INS = id_ex_skid_pkg::NOP_INS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_ins_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_wen,
  input  logic [OH_W-1:0] in_oh,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_ins_addr,
  output logic [4:0]      out_rd_addr,
  output logic            out_rd_wen,
  output logic [OH_W-1:0] out_oh
`ifdef ID_EX_SKID_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  import id_ex_skid_pkg::*;

  localparam int BW = 3*XLEN + 32 + 5 + 1 + OH_W;
  localparam logic [BW-1:0] NOP_VEC = {{(2*XLEN){1'b0}}, NOP_INS, {(XLEN+6+OH_W){1'b0}}};

  // Slot 0 drives execute, slot 1 is the skid entry.
  logic [1:0]    slot_load;
  logic [1:0]    slot_clear;
  logic [1:0]    slot_valid;
  logic [BW-1:0] slot_d [2];
  logic [BW-1:0] slot_q [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      id_ex_slot #(
        .W       (BW),
        .NOP_VAL (NOP_VEC)
      ) u_slot (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (slot_load[gi]),
        .clear (slot_clear[gi]),
        .d     (slot_d[gi]),
        .valid (slot_valid[gi]),
        .q     (slot_q[gi])
      );
    end
  endgenerate

  skid_state_e   state;
  logic          in_fire;
  logic [BW-1:0] in_bundle;

  assign state     = skid_state_e'({slot_valid[1], slot_valid[0]});
  assign in_ready  = !slot_valid[1];
  assign in_fire   = in_valid && in_ready;
  assign in_bundle = {in_op1, in_op2, in_ins, in_ins_addr, in_rd_addr, in_rd_wen, in_oh};

  always_comb begin
    slot_load  = 2'b00;
    slot_clear = 2'b00;
    slot_d[0]  = in_bundle;
    slot_d[1]  = in_bundle;
    if (flush) begin
      slot_clear = 2'b11;
    end else begin
      case (state)
        ST_EMPTY: slot_load[0] = in_fire;
        ST_ONE: begin
          if (out_ready) begin
            slot_load[0]  = in_fire;
            slot_clear[0] = !in_fire;
          end else begin
            slot_load[1] = in_fire;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            slot_load[0]  = 1'b1;
            slot_d[0]     = slot_q[1];
            slot_clear[1] = 1'b1;
          end
        end
        default: slot_clear = 2'b11;
      endcase
    end
  end

  assign out_valid = slot_valid[0];
  assign {out_op1, out_op2, out_ins, out_ins_addr, out_rd_addr, out_rd_wen, out_oh} = slot_q[0];

`ifdef ID_EX_SKID_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (slot_valid[0] && !out_ready) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (flush && (slot_valid != 2'b00)) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid: reset, single bundle, streaming, back-pressure,
// flush and asynchronous reset; also checks counters when ID_EX_SKID_PERF_EN is set.
module tb_id_ex_skid;

  localparam int BW = 141;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op1, in_op2, in_ins, in_ins_addr;
  logic [4:0]  in_rd_addr;
  logic        in_rd_wen;
  logic [6:0]  in_oh;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1, out_op2, out_ins, out_ins_addr;
  logic [4:0]  out_rd_addr;
  logic        out_rd_wen;
  logic [6:0]  out_oh;
`ifdef ID_EX_SKID_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  id_ex_skid dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_ins       (in_ins),
    .in_ins_addr  (in_ins_addr),
    .in_rd_addr   (in_rd_addr),
    .in_rd_wen    (in_rd_wen),
    .in_oh        (in_oh),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_op1      (out_op1),
    .out_op2      (out_op2),
    .out_ins      (out_ins),
    .out_ins_addr (out_ins_addr),
    .out_rd_addr  (out_rd_addr),
    .out_rd_wen   (out_rd_wen),
    .out_oh       (out_oh)
`ifdef ID_EX_SKID_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  logic [BW-1:0] out_bundle;
  assign out_bundle = {out_op1, out_op2, out_ins, out_ins_addr, out_rd_addr, out_rd_wen, out_oh};

  // Hand-chosen pattern for bundle k: distinct per field and per k.
  function automatic logic [BW-1:0] mk(input int k);
    logic [31:0] op1, op2, ins, addr;
    logic [4:0]  rd;
    logic [6:0]  oh;
    op1  = 32'hA000_0000 + k;
    op2  = 32'hB000_0000 + k;
    ins  = 32'h0000_0013 + (k << 7);
    addr = 32'h0000_1000 + 4 * k;
    rd   = 5'(k);
    oh   = 7'(19 + (k % 9));
    return {op1, op2, ins, addr, rd, 1'b1, oh};
  endfunction

  task automatic drive(input int k);
    {in_op1, in_op2, in_ins, in_ins_addr, in_rd_addr, in_rd_wen, in_oh} = mk(k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(0); in_rd_wen = 1'b0;

    // Reset
    step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_ins", out_ins, 32'h00000013);
    rst_n = 1'b1;
    step();
    check("rel_out_valid", out_valid, 1'b0);
    check("rel_out_ins", out_ins, 32'h00000013);
    check("rel_out_rd_wen", out_rd_wen, 1'b0);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_oh", out_oh, 7'd0);

    // Single ADDI x5,x1,7
    out_ready = 1'b1; in_valid = 1'b1;
    in_op1 = 32'h11; in_op2 = 32'h7; in_ins = 32'h00708293; in_ins_addr = 32'h80;
    in_rd_addr = 5'd5; in_rd_wen = 1'b1; in_oh = 7'd19;
    step();
    in_valid = 1'b0;
    check("addi_valid", out_valid, 1'b1);
    check("addi_op1", out_op1, 32'h11);
    check("addi_op2", out_op2, 32'h7);
    check("addi_ins", out_ins, 32'h00708293);
    check("addi_addr", out_ins_addr, 32'h80);
    check("addi_rd", out_rd_addr, 5'd5);
    check("addi_wen", out_rd_wen, 1'b1);
    check("addi_oh", out_oh, 7'd19);
    step();
    check("addi_drain_valid", out_valid, 1'b0);
    check("addi_drain_ins", out_ins, 32'h00000013);
    check("addi_drain_oh", out_oh, 7'd0);

    // Streaming 8 bundles
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(k);
      step();
      check($sformatf("stream%0d_valid", k), out_valid, 1'b1);
      check($sformatf("stream%0d_data", k), out_bundle, mk(k));
      check($sformatf("stream%0d_ready", k), in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid", out_valid, 1'b0);

    // Back-pressure: 3 bundles offered while execute stalls
    out_ready = 1'b0; in_valid = 1'b1; drive(11);
    step();
    check("bp_c1_data", out_bundle, mk(11));
    check("bp_c1_ready", in_ready, 1'b1);
    drive(12);
    step();
    check("bp_c2_data", out_bundle, mk(11));
    check("bp_c2_ready", in_ready, 1'b0);
    drive(13);
    step();
    check("bp_c3_data", out_bundle, mk(11));
    check("bp_c3_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    check("bp_d2_data", out_bundle, mk(12));
    check("bp_d2_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_d3_valid", out_valid, 1'b1);
    check("bp_d3_data", out_bundle, mk(13));
    step();
    check("bp_end_valid", out_valid, 1'b0);

    // Flush while TWO, with a new bundle offered
    out_ready = 1'b0; in_valid = 1'b1; drive(21);
    step();
    drive(22);
    step();
    check("fl_two_ready", in_ready, 1'b0);
    flush = 1'b1; drive(23);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_valid", out_valid, 1'b0);
    check("fl_ready", in_ready, 1'b1);
    check("fl_oh", out_oh, 7'd0);
    check("fl_ins", out_ins, 32'h00000013);
`ifdef ID_EX_SKID_PERF_EN
    check("perf_stall", stall_cnt, 32'd4);
    check("perf_flush", flush_cnt, 32'd1);
`endif
    step();
    check("fl_after_valid", out_valid, 1'b0);
    check("fl_after_data", out_bundle, {64'd0, 32'h00000013, 45'd0});

    // Asynchronous reset while TWO
    out_ready = 1'b0; in_valid = 1'b1; drive(31);
    step();
    drive(32);
    step();
    in_valid = 1'b0;
    check("ar_two_ready", in_ready, 1'b0);
    check("ar_two_data", out_bundle, mk(31));
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_ready", in_ready, 1'b1);
    check("ar_data", out_bundle, {64'd0, 32'h00000013, 45'd0});
`ifdef ID_EX_SKID_PERF_EN
    check("ar_stall", stall_cnt, 32'd0);
`endif
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("ar_rel_valid", out_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
- Pipeline boundary register between the decode stage and the execute stage of the RV32I core.
- Captures the decoded bundle (op1, op2, instruction, PC, rd address, rd write-enable, op code `oh`) under a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput while execute back-pressures.
- Synchronous flush squashes in-flight decoded instructions on a taken branch or jump.

Parameters:
- XLEN, 32, datapath width for op1/op2/instruction/PC.
- OH_W, 7, width of the op code field `oh`.
- NOP_INS, 32'h00000013, instruction word driven when the slot is empty (ADDI x0,x0,0).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode bundle valid
- in_ready  out  1  block can accept a bundle this cycle
- in_op1  in  XLEN  operand 1
- in_op2  in  XLEN  operand 2
- in_ins  in  32  instruction word
- in_ins_addr  in  XLEN  instruction PC
- in_rd_addr  in  5  destination register
- in_rd_wen  in  1  destination write enable
- in_oh  in  OH_W  op code
- flush  in  1  squash all held and incoming bundles
- out_valid  out  1  execute bundle valid
- out_ready  in  1  execute consumes this cycle
- out_op1, out_op2, out_ins, out_ins_addr, out_rd_addr, out_rd_wen, out_oh  out  (widths as inputs)  registered bundle to execute

Behaviour:
- Reset (async assert, sync release):
  - states → EMPTY; out_valid=0.
  - out_ins=NOP_INS; all other out_* = 0 (out_rd_wen=0, out_oh=0).
  - Skid register cleared; in_ready=1 after release.
- Transfers:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- States, encoded by {skid_valid, out_valid}:
  - EMPTY: neither slot valid.
  - ONE: output slot valid.
  - TWO: output and skid slots valid.
- in_ready = !skid_valid, driven directly from a register with no combinational path from out_ready.
- Transitions (flush=0):
  - EMPTY: input transfer → ONE, bundle into output slot; latency 1 cycle.
  - ONE, output transfer with no input transfer → EMPTY.
  - ONE, output transfer and input transfer → ONE, new bundle overwrites output slot.
  - ONE, no output transfer and input transfer → TWO, bundle into skid slot.
  - ONE, no transfers → hold.
  - TWO: in_ready=0. out_ready=1 → skid moves to output slot → ONE. Otherwise hold.
- Output payload is held stable while out_valid=1 & out_ready=0.
- When out_valid=0, out_rd_wen=0, out_oh=0 and out_ins=NOP_INS, so no bubble can write the register file.
- Flush:
  - Synchronous, highest priority. Next edge → EMPTY, both slots invalidated and payload reset to NOP values.
  - An input presented in the same cycle is dropped.
  - An output transfer in the same cycle still counts as consumed by execute.
- Widths: all fields pass through unmodified; no arithmetic on the datapath.
- Async reset mid-operation discards both slots immediately.

Optional Feature:
- Macro: ID_EX_SKID_PERF_EN.
- When defined:
  - Adds output ports stall_cnt (32 b) and flush_cnt (32 b).
  - stall_cnt increments each cycle out_valid & !out_ready.
  - flush_cnt increments each cycle flush=1 with at least one slot valid.
  - Both counters wrap at 2^32 and reset to 0 on rst_n.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared core package holds:
  - NOP_INS constant.
  - OH_W and op code localparams (LUI=1, AUIPC=2, JAL=3, JALR=4, branch 5-10, loads 11-15, ALU-imm 19-27, ALU-reg 28-37).
  - A packed decode-bundle typedef (op1, op2, ins, ins_addr, rd_addr, rd_wen, oh) shared with decode and execute.
- One sub-module: id_ex_slot, a single bundle register with load/clear-to-NOP enables, instantiated twice (output slot, skid slot).

Test Plan:
- Reset release, no input → out_valid=0, out_ins=32'h00000013, out_rd_wen=0, in_ready=1.
- Single ADDI bundle (in_oh=19, in_rd_addr=5, in_op2=32'h7), out_ready=1 → next cycle out_valid=1 with identical fields; following cycle out_valid=0.
- Streaming 8 bundles back-to-back, out_ready=1 → 8 outputs on consecutive cycles, order preserved, in_ready stays 1.
- out_ready=0 with 3 bundles offered → first held on output, second in skid, in_ready=0 on cycle 3, third not accepted. Then out_ready=1 → bundles 1, 2, 3 delivered in order with no loss or duplication.
- TWO state, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, out_oh=0; the flushed bundles never appear.
- rst_n asserted low while in TWO mid-stream → outputs return to reset values without waiting for a clock edge. With ID_EX_SKID_PERF_EN, 4 stalled cycles → stall_cnt=4.
